multicycle_control_unit: RTL

Moore-style control FSM for the 32-bit multicycle MIPS core. It sits directly upstream of the datapath. It consumes the latched instruction fields (op, funct) and the ALU zero flag, and drives every datapath control strobe and mux select. Each instruction takes 3–5 clock cycles, walking from a shared fetch/decode prologue into a per-class execute sequence.

---
 rtl/multicycle_control_unit.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle MIPS core: decodes the registered state into
// datapath strobes and mux selects; PCen additionally folds in the branch-taken term.
module multicycle_control_unit #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               PCen,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic               PCsrc,
  output logic               Ori,
  output logic               Jump,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    BEQ     = 4'd8,
    ADDIEX  = 4'd9,
    ORIEX   = 4'd10,
    GPIOEX  = 4'd11,
    IWB     = 4'd12,
    JUMP    = 4'd13
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Returns {supported, alu_control} for an R-type function field.
  function automatic logic [3:0] funct_decode(input logic [5:0] f);
    logic [3:0] r;
    case (f)
      6'h20:   r = {1'b1, ALU_ADD};
      6'h22:   r = {1'b1, ALU_SUB};
      6'h24:   r = {1'b1, ALU_AND};
      6'h25:   r = {1'b1, ALU_OR};
      6'h2A:   r = {1'b1, ALU_SLT};
      default: r = {1'b0, ALU_AND};
    endcase
    return r;
  endfunction

  state_t     state_r;
  state_t     state_next_s;
  logic [3:0] funct_dec_s;

  logic       pcwrite_s;
  logic       branch_s;
  logic       iord_s;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regdst_s;
  logic       memtoreg_s;
  logic       regwrite_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic [2:0] alucontrol_s;
  logic       pcsrc_s;
  logic       ori_s;
  logic       jump_s;

  assign funct_dec_s = funct_decode(funct);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = FETCH;
    case (state_r)
      FETCH:   state_next_s = DECODE;
      DECODE: begin
        case (op)
          6'h23, 6'h2B: state_next_s = MEMADR;
          6'h00: begin
            if (funct_dec_s[3]) begin
              state_next_s = RTYPEEX;
            end else begin
              state_next_s = FETCH;
            end
          end
          6'h04:   state_next_s = BEQ;
          6'h08:   state_next_s = ADDIEX;
          6'h0D:   state_next_s = ORIEX;
          6'h3F:   state_next_s = GPIOEX;
          6'h02:   state_next_s = JUMP;
          default: state_next_s = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == 6'h23) begin
          state_next_s = MEMRD;
        end else begin
          state_next_s = MEMWR;
        end
      end
      MEMRD:   state_next_s = MEMWB;
      RTYPEEX: state_next_s = ALUWB;
      ADDIEX:  state_next_s = IWB;
      ORIEX:   state_next_s = IWB;
      GPIOEX:  state_next_s = IWB;
      default: state_next_s = FETCH;
    endcase
  end

  // Per-state control decode; depends only on the registered state (and funct in RTYPEEX).
  always_comb begin
    pcwrite_s    = 1'b0;
    branch_s     = 1'b0;
    iord_s       = 1'b0;
    memwrite_s   = 1'b0;
    irwrite_s    = 1'b0;
    regdst_s     = 1'b0;
    memtoreg_s   = 1'b0;
    regwrite_s   = 1'b0;
    alusrca_s    = 1'b0;
    alusrcb_s    = 2'b00;
    alucontrol_s = ALU_AND;
    pcsrc_s      = 1'b0;
    ori_s        = 1'b0;
    jump_s       = 1'b0;
    case (state_r)
      FETCH: begin
        alusrcb_s    = 2'b01;
        alucontrol_s = ALU_ADD;
        irwrite_s    = 1'b1;
        pcwrite_s    = 1'b1;
      end
      DECODE: begin
        alusrcb_s    = 2'b11;
        alucontrol_s = ALU_ADD;
      end
      MEMADR: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = 2'b10;
        alucontrol_s = ALU_ADD;
      end
      MEMRD:   iord_s = 1'b1;
      MEMWB: begin
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
      end
      RTYPEEX: begin
        alusrca_s    = 1'b1;
        alucontrol_s = funct_dec_s[2:0];
      end
      ALUWB: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
      end
      BEQ: begin
        alusrca_s    = 1'b1;
        alucontrol_s = ALU_SUB;
        pcsrc_s      = 1'b1;
        branch_s     = 1'b1;
      end
      ADDIEX: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = 2'b10;
        alucontrol_s = ALU_ADD;
      end
      ORIEX: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = 2'b10;
        alucontrol_s = ALU_OR;
      end
      GPIOEX: begin
        ori_s        = 1'b1;
        alusrca_s    = 1'b1;
        alusrcb_s    = 2'b10;
        alucontrol_s = ALU_ADD;
      end
      IWB:     regwrite_s = 1'b1;
      JUMP: begin
        jump_s    = 1'b1;
        pcwrite_s = 1'b1;
      end
      default: jump_s = 1'b0;
    endcase
  end

  // Holding reset low blanks every strobe at once, so an aborted store or write-back cannot complete.
  assign PCen       = reset & (pcwrite_s | (branch_s & zero));
  assign IorD       = reset & iord_s;
  assign MemWrite   = reset & memwrite_s;
  assign IRWrite    = reset & irwrite_s;
  assign RegDst     = reset & regdst_s;
  assign MemtoReg   = reset & memtoreg_s;
  assign RegWrite   = reset & regwrite_s;
  assign ALUSrcA    = reset & alusrca_s;
  assign ALUSrcB    = {2{reset}} & alusrcb_s;
  assign ALUControl = {3{reset}} & alucontrol_s;
  assign PCsrc      = reset & pcsrc_s;
  assign Ori        = reset & ori_s;
  assign Jump       = reset & jump_s;
  assign state_o    = STATE_W'(state_r);

endmodule
